// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port (A) and a video/DMA port (B) share one
// memory sequencer. One access at a time, every output registered, a dead
// RELEASE cycle between accesses, and an abort path if the sequencer never
// answers.
module mem_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_data_in,
    input  logic        a_read_en,
    input  logic        a_write_en,
    output logic [15:0] a_data_out,
    output logic        a_done,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_data_in,
    input  logic        b_read_en,
    input  logic        b_write_en,
    output logic [15:0] b_data_out,
    output logic        b_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    output logic        busy,
    output logic        grant_b,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [7:0] CNT_MAX     = 8'hFF;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_b_q, last_b_d;       // 1 = port B won the most recent grant
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_data_in_q, mem_data_in_d;
    logic        mem_read_en_q, mem_read_en_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic [15:0] a_data_out_q, a_data_out_d;
    logic [15:0] b_data_out_q, b_data_out_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic        busy_q, busy_d;
    logic        grant_b_q, grant_b_d;
    logic        timeout_err_q, timeout_err_d;

    logic        a_req;
    logic        b_req;
    logic        pick_b;

    // Decode requests and choose the winner should IDLE see them this cycle.
    always_comb begin
        a_req  = a_read_en | a_write_en;
        b_req  = b_read_en | b_write_en;
        pick_b = 1'b0;
        if (a_req && b_req) begin
            if (ROUND_ROBIN != 0) begin
                pick_b = ~last_b_q;
            end else begin
                pick_b = 1'b0;
            end
        end else if (b_req) begin
            pick_b = 1'b1;
        end else begin
            pick_b = 1'b0;
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_b_d       = last_b_q;
        mem_addr_d     = mem_addr_q;
        mem_data_in_d  = mem_data_in_q;
        mem_read_en_d  = mem_read_en_q;
        mem_write_en_d = mem_write_en_q;
        a_data_out_d   = a_data_out_q;
        b_data_out_d   = b_data_out_q;
        a_done_d       = 1'b0;
        b_done_d       = 1'b0;
        timeout_err_d  = timeout_err_q;

        case (state_q)
            IDLE: begin
                mem_read_en_d  = 1'b0;
                mem_write_en_d = 1'b0;
                if (a_req || b_req) begin
                    state_d  = pick_b ? GRANT_B : GRANT_A;
                    last_b_d = pick_b;
                    cnt_d    = 8'd0;
                    // A read wins when both enables are high on one port.
                    if (pick_b) begin
                        mem_addr_d     = b_addr;
                        mem_data_in_d  = b_data_in;
                        mem_read_en_d  = b_read_en;
                        mem_write_en_d = ~b_read_en;
                    end else begin
                        mem_addr_d     = a_addr;
                        mem_data_in_d  = a_data_in;
                        mem_read_en_d  = a_read_en;
                        mem_write_en_d = ~a_read_en;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT_A, GRANT_B: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (mem_done) begin
                    mem_read_en_d  = 1'b0;
                    mem_write_en_d = 1'b0;
                    state_d        = RELEASE;
                    if (state_q == GRANT_B) begin
                        b_done_d = 1'b1;
                        if (mem_read_en_q) begin
                            b_data_out_d = mem_data_out;
                        end else begin
                            b_data_out_d = b_data_out_q;
                        end
                    end else begin
                        a_done_d = 1'b1;
                        if (mem_read_en_q) begin
                            a_data_out_d = mem_data_out;
                        end else begin
                            a_data_out_d = a_data_out_q;
                        end
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    // Abort: complete the handshake but keep the old read data.
                    mem_read_en_d  = 1'b0;
                    mem_write_en_d = 1'b0;
                    timeout_err_d  = 1'b1;
                    state_d        = RELEASE;
                    if (state_q == GRANT_B) begin
                        b_done_d = 1'b1;
                    end else begin
                        a_done_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            RELEASE: begin
                mem_read_en_d  = 1'b0;
                mem_write_en_d = 1'b0;
                state_d        = IDLE;
            end

            default: begin
                mem_read_en_d  = 1'b0;
                mem_write_en_d = 1'b0;
                state_d        = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        grant_b_d = (state_d == GRANT_B);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            last_b_q       <= 1'b1;
            mem_addr_q     <= 16'h0000;
            mem_data_in_q  <= 16'h0000;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            a_data_out_q   <= 16'h0000;
            b_data_out_q   <= 16'h0000;
            a_done_q       <= 1'b0;
            b_done_q       <= 1'b0;
            busy_q         <= 1'b0;
            grant_b_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_b_q       <= last_b_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            a_data_out_q   <= a_data_out_d;
            b_data_out_q   <= b_data_out_d;
            a_done_q       <= a_done_d;
            b_done_q       <= b_done_d;
            busy_q         <= busy_d;
            grant_b_q      <= grant_b_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign a_data_out   = a_data_out_q;
    assign a_done       = a_done_q;
    assign b_data_out   = b_data_out_q;
    assign b_done       = b_done_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_in  = mem_data_in_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign busy         = busy_q;
    assign grant_b      = grant_b_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 1 is round-robin, instance 0 fixed-priority.
// Both share the requester stimulus; each has its own 2-wait-state memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_addr = 16'h0000, a_data_in = 16'h0000;
    logic        a_read_en = 1'b0, a_write_en = 1'b0;
    logic [15:0] b_addr = 16'h0000, b_data_in = 16'h0000;
    logic        b_read_en = 1'b0, b_write_en = 1'b0;
    logic        stray = 1'b0;       // injected completion pulses
    logic        mem_stall = 1'b0;   // memory never answers

    logic [15:0] a_dout [2];
    logic [15:0] b_dout [2];
    logic        a_done [2];
    logic        b_done [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_din  [2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic [15:0] m_dout [2];
    logic        m_done [2];
    logic        m_done_in [2];
    logic        busy   [2];
    logic        grant_b [2];
    logic        terr   [2];

    logic [15:0] mem [2][256];
    logic [2:0]  wcnt [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign m_done_in[0] = m_done[0] | stray;
    assign m_done_in[1] = m_done[1] | stray;

    mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(15)) u_fixed (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_data_in(a_data_in), .a_read_en(a_read_en), .a_write_en(a_write_en),
        .a_data_out(a_dout[0]), .a_done(a_done[0]),
        .b_addr(b_addr), .b_data_in(b_data_in), .b_read_en(b_read_en), .b_write_en(b_write_en),
        .b_data_out(b_dout[0]), .b_done(b_done[0]),
        .mem_addr(m_addr[0]), .mem_data_in(m_din[0]), .mem_read_en(m_rd[0]), .mem_write_en(m_wr[0]),
        .mem_data_out(m_dout[0]), .mem_done(m_done_in[0]),
        .busy(busy[0]), .grant_b(grant_b[0]), .timeout_err(terr[0])
    );

    mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(15)) u_rr (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_data_in(a_data_in), .a_read_en(a_read_en), .a_write_en(a_write_en),
        .a_data_out(a_dout[1]), .a_done(a_done[1]),
        .b_addr(b_addr), .b_data_in(b_data_in), .b_read_en(b_read_en), .b_write_en(b_write_en),
        .b_data_out(b_dout[1]), .b_done(b_done[1]),
        .mem_addr(m_addr[1]), .mem_data_in(m_din[1]), .mem_read_en(m_rd[1]), .mem_write_en(m_wr[1]),
        .mem_data_out(m_dout[1]), .mem_done(m_done_in[1]),
        .busy(busy[1]), .grant_b(grant_b[1]), .timeout_err(terr[1])
    );

    // Memory model: two wait states, done raised on the 4th edge an enable is seen, one-cycle pulse.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || mem_stall || !(m_rd[i] || m_wr[i])) begin
                m_done[i] <= 1'b0;
                wcnt[i]   <= 3'd0;
            end else if (m_done[i]) begin
                m_done[i] <= 1'b0;
                wcnt[i]   <= 3'd0;
            end else if (wcnt[i] == 3'd3) begin
                m_done[i] <= 1'b1;
                if (m_wr[i]) mem[i][m_addr[i][7:0]] <= m_din[i];
                else         m_dout[i] <= mem[i][m_addr[i][7:0]];
            end else begin
                wcnt[i] <= wcnt[i] + 3'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port_b;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
    } vec_t;

    task automatic set_req(input logic port_b, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] din);
        if (port_b) begin
            b_addr = addr; b_data_in = din; b_read_en = rd; b_write_en = wr;
        end else begin
            a_addr = addr; a_data_in = din; a_read_en = rd; a_write_en = wr;
        end
    endtask

    // One uncontended access, checked on both instances.
    task automatic do_access(input vec_t v, input int row);
        int done_at [2];
        int n_done  [2];
        int other   [2];
        set_req(v.port_b, v.rd, v.wr, v.addr, v.din);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("r%0d_i%0d_rd_en", row, i), 32'(m_rd[i]), 32'(v.rd));
            chk($sformatf("r%0d_i%0d_wr_en", row, i), 32'(m_wr[i]), 32'(v.wr & ~v.rd));
            chk($sformatf("r%0d_i%0d_addr", row, i), 32'(m_addr[i]), 32'(v.addr));
            chk($sformatf("r%0d_i%0d_grant_b", row, i), 32'(grant_b[i]), 32'(v.port_b));
            done_at[i] = -1; n_done[i] = 0; other[i] = 0;
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if ((v.port_b ? b_done[i] : a_done[i]) == 1'b1) begin
                    n_done[i]++;
                    if (done_at[i] < 0) done_at[i] = k;
                end
                if ((v.port_b ? a_done[i] : b_done[i]) == 1'b1) other[i]++;
            end
            if (k == 6) set_req(v.port_b, 1'b0, 1'b0, v.addr, v.din);
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("r%0d_i%0d_latency", row, i), 32'(done_at[i]), 32'd5);
            chk($sformatf("r%0d_i%0d_done_pulses", row, i), 32'(n_done[i]), 32'd1);
            chk($sformatf("r%0d_i%0d_other_done", row, i), 32'(other[i]), 32'd0);
            chk($sformatf("r%0d_i%0d_dout", row, i),
                32'(v.port_b ? b_dout[i] : a_dout[i]), 32'(v.exp_dout));
            chk($sformatf("r%0d_i%0d_idle_busy", row, i), 32'(busy[i]), 32'd0);
        end
    endtask

    vec_t vt [9];

    initial begin
        int a_first, a_second, b_first, a_cnt, both, b_early, tmo_at, n_ad;

        vt[0] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        vt[1] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vt[2] = '{1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000};
        vt[3] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vt[4] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vt[5] = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555, 16'h1234};
        vt[6] = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vt[7] = '{1'b0, 1'b0, 1'b1, 16'h0030, 16'h00FF, 16'h1234};
        vt[8] = '{1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h00FF};

        // Reset values.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_i%0d_busy", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_i%0d_grant_b", i), 32'(grant_b[i]), 32'd0);
            chk($sformatf("rst_i%0d_terr", i), 32'(terr[i]), 32'd0);
            chk($sformatf("rst_i%0d_dones", i), 32'({a_done[i], b_done[i]}), 32'd0);
            chk($sformatf("rst_i%0d_enables", i), 32'({m_rd[i], m_wr[i]}), 32'd0);
            chk($sformatf("rst_i%0d_mem_addr", i), 32'(m_addr[i]), 32'd0);
            chk($sformatf("rst_i%0d_mem_din", i), 32'(m_din[i]), 32'd0);
            chk($sformatf("rst_i%0d_a_dout", i), 32'(a_dout[i]), 32'd0);
            chk($sformatf("rst_i%0d_b_dout", i), 32'(b_dout[i]), 32'd0);
        end

        // Single accesses from the table.
        for (int r = 0; r < 9; r++) do_access(vt[r], r);

        // Contention on the round-robin instance: A first, then A re-requests while B waits -> B.
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        set_req(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000);
        a_first = -1; a_second = -1; b_first = -1; both = 0;
        @(posedge clk); #1;
        chk("rr_first_grant_b", 32'(grant_b[1]), 32'd0);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (a_done[1] && b_done[1]) both++;
            if (a_done[1]) begin
                if (a_first < 0) a_first = k;
                else if (a_second < 0) a_second = k;
            end
            if (b_done[1] && b_first < 0) b_first = k;
            if (k == 7) chk("rr_second_grant_b", 32'(grant_b[1]), 32'd1);
            if (k == 5)  set_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
            if (k == 6)  set_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
            if (k == 12) set_req(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
            if (k == 19) set_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
        end
        chk("rr_a_first_done", 32'(a_first), 32'd5);
        chk("rr_b_done", 32'(b_first), 32'd12);
        chk("rr_a_second_done", 32'(a_second), 32'd19);
        chk("rr_both_done", 32'(both), 32'd0);
        chk("rr_a_dout", 32'(a_dout[1]), 32'h1234);
        chk("rr_b_dout", 32'(b_dout[1]), 32'h00FF);

        // Timeout: memory silent, A read aborts after TIMEOUT+1 grant cycles.
        chk("tmo_terr_before", 32'(terr[1]), 32'd0);
        mem_stall = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        tmo_at = -1; n_ad = 0; b_early = 0;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (a_done[1]) begin
                n_ad++;
                if (tmo_at < 0) tmo_at = k;
            end
            if (b_done[1]) b_early++;
            if (k == 16) chk("tmo_rd_en_low", 32'(m_rd[1]), 32'd0);
            if (k == 17) set_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        end
        mem_stall = 1'b0;
        chk("tmo_done_edge", 32'(tmo_at), 32'd16);
        chk("tmo_done_pulses", 32'(n_ad), 32'd1);
        chk("tmo_b_done", 32'(b_early), 32'd0);
        chk("tmo_terr", 32'(terr[1]), 32'd1);
        chk("tmo_a_dout_kept", 32'(a_dout[1]), 32'h1234);
        chk("tmo_idle", 32'(busy[1]), 32'd0);

        // Stray completions in IDLE are ignored; error flag stays set.
        stray = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stray_idle_%0d_done", k), 32'({a_done[1], b_done[1]}), 32'd0);
            chk($sformatf("stray_idle_%0d_busy", k), 32'(busy[1]), 32'd0);
        end
        stray = 1'b0;
        chk("terr_sticky", 32'(terr[1]), 32'd1);

        // Reset mid-access, then a late completion from the sequencer.
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        chk("midrst_busy", 32'(busy[1]), 32'd0);
        chk("midrst_terr", 32'(terr[1]), 32'd0);
        chk("midrst_a_dout", 32'(a_dout[1]), 32'd0);
        chk("midrst_mem_addr", 32'(m_addr[1]), 32'd0);
        chk("midrst_rd_en", 32'(m_rd[1]), 32'd0);
        stray = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst_late_%0d_a_done", k), 32'(a_done[1]), 32'd0);
            chk($sformatf("midrst_late_%0d_busy", k), 32'(busy[1]), 32'd0);
        end
        stray = 1'b0;
        @(posedge clk); #1;
        do_access(vt[1], 9);

        // Fixed priority: A keeps requesting, B starves until A drops.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        set_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        a_cnt = 0; a_first = -1; b_first = -1; both = 0;
        @(posedge clk); #1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (a_done[0] && b_done[0]) both++;
            if (a_done[0]) begin
                a_cnt++;
                a_first = k;
            end
            if (b_done[0] && b_first < 0) b_first = k;
            if (k == 7 || k == 14) chk($sformatf("fix_grant_b_%0d", k), 32'(grant_b[0]), 32'd0);
            if (k == 5 || k == 12) set_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
            if (k == 6 || k == 13) set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
            if (k == 19) set_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
            if (k == 26) set_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        end
        chk("fix_a_count", 32'(a_cnt), 32'd3);
        chk("fix_a_last_done", 32'(a_first), 32'd19);
        chk("fix_b_done", 32'(b_first), 32'd26);
        chk("fix_both_done", 32'(both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
